ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk input 1 (rising edge, all state), then i_rst input 1 (synchronous, active-high).
REQ-002 The block SHALL have these inputs:
- i_valid, 1: an EX instruction is presented.
- i_ALURes, 64 signed: ALU result; also the memory address.
- i_Z, 1: ALU zero flag.
- i_N, 1: ALU negative flag.
- i_rt_data, 64: store data.
- i_rd, 5: destination register.
- i_branch_target, 64: computed branch PC.
- i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg, 1 each: control bits.
- i_set_flags, 1: the instruction is ADDS/SUBS/ANDS.
- i_branch_type, 3: 0 none, 1 B, 2 CBZ, 3 CBNZ, 4 B.EQ, 5 B.NE, 6 B.LT, 7 B.GE.
- i_stall, 1: MEM is not accepting this cycle.
- i_flush, 1: kill the stage contents.
REQ-003 The block SHALL have these registered outputs:
- o_valid, 1.
- o_ALURes, 64.
- o_rt_data, 64.
- o_rd, 5.
- o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg, 1 each.
- o_take_branch, 1.
- o_branch_target, 64.
- o_flag_Z, o_flag_N, 1 each: architectural NZ flags.
- o_misalign, 1.
REQ-004 The block SHALL have one combinational output, o_ready, 1, equal to ~i_stall.

Function
REQ-005 Update priority at each rising edge SHALL be i_rst, then i_flush, then i_stall, then normal capture.
REQ-006 Normal capture (no rst/flush/stall) SHALL load every data output and o_rd from its input. o_valid SHALL load i_valid. Latency is 1 cycle.
REQ-007 When i_valid=0 on capture, the block SHALL write a bubble:
- o_valid, o_MemRead, o_MemWrite, o_RegWrite, o_take_branch, o_misalign all 0.
- Data outputs may load anything.
REQ-008 Stall (i_stall=1, no flush) SHALL hold every output register and the flag register unchanged. The incoming instruction is not consumed; upstream must hold it.
REQ-009 Flush (i_flush=1) SHALL force o_valid, o_MemRead, o_MemWrite, o_RegWrite, o_take_branch and o_misalign to 0. The flag register is unchanged. Flush overrides a simultaneous stall.
REQ-010 The flag register SHALL load o_flag_Z<=i_Z and o_flag_N<=i_N only on a normal capture with i_valid=1 and i_set_flags=1; otherwise it holds.
REQ-011 o_take_branch SHALL be computed at capture from i_branch_type, i_Z and the flag register value before that edge's update:
- 1 B: taken always.
- 2 CBZ: taken if i_Z=1.
- 3 CBNZ: taken if i_Z=0.
- 4 B.EQ: taken if flag_Z=1.
- 5 B.NE: taken if flag_Z=0.
- 6 B.LT: taken if flag_N=1.
- 7 B.GE: taken if flag_N=0.
- 0: not taken.
REQ-012 CBZ/CBNZ SHALL ignore i_N, because the ALU pass-through op does not refresh N.
REQ-013 If i_set_flags=1 and i_branch_type is 4..7 in the same instruction, the branch SHALL use the old flags. The same-edge flag update SHALL still occur.
REQ-014 o_misalign SHALL be set on capture when i_valid & (i_MemRead|i_MemWrite) & (i_ALURes[2:0]!=0). In that case o_MemRead, o_MemWrite and o_RegWrite SHALL be captured as 0.
REQ-015 o_branch_target SHALL be captured unmodified (no alignment or width change). o_ALURes and o_rt_data SHALL be bit-exact 64-bit copies.
REQ-016 Outputs SHALL depend only on registered state, except o_ready. There is no combinational path from inputs to registered outputs.

Reset
REQ-017 When i_rst=1 at an edge, every registered output, including o_flag_Z, o_flag_N and o_branch_target, SHALL become 0.
REQ-018 Reset SHALL override i_flush, i_stall and i_valid in the same cycle.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction.
REQ-020 The first capture after reset SHALL behave as a normal capture.

Verification
REQ-021 Capture: i_valid=1, i_ALURes=0x10, i_RegWrite=1, i_rd=5 -> next cycle o_valid=1, o_ALURes=0x10, o_rd=5, o_RegWrite=1, o_take_branch=0.
REQ-022 Flags then branch: SUBS with i_set_flags=1, i_Z=1, i_N=0; next cycle B.EQ (type 4) -> o_flag_Z=1 after the first edge; o_take_branch=1 after the second edge. Repeat with B.NE -> o_take_branch=0.
REQ-023 CBZ: i_branch_type=2, i_Z=1, i_N=1, flag_Z=0 -> o_take_branch=1. With i_Z=0 -> 0.
REQ-024 Stall then flush:
- i_stall=1 for 3 cycles with changing inputs -> outputs frozen.
- i_stall=1 and i_flush=1 together -> o_valid=0, flags unchanged.
REQ-025 Misaligned load: i_MemRead=1, i_ALURes=0x1004 -> o_misalign=1, o_MemRead=0, o_RegWrite=0, o_ALURes=0x1004.
REQ-026 Reset: i_rst=1 while o_valid=1, flags=11 and stalled -> all registered outputs 0 next cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the EX results, resolves branches against
// the architectural NZ flags and zeroes memory and writeback controls on misaligned accesses.
module ex_mem_stage (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic signed [63:0] i_ALURes,
  input  logic               i_Z,
  input  logic               i_N,
  input  logic        [63:0] i_rt_data,
  input  logic        [4:0]  i_rd,
  input  logic        [63:0] i_branch_target,
  input  logic               i_MemRead,
  input  logic               i_MemWrite,
  input  logic               i_RegWrite,
  input  logic               i_MemToReg,
  input  logic               i_set_flags,
  input  logic        [2:0]  i_branch_type,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic               o_ready,
  output logic               o_valid,
  output logic        [63:0] o_ALURes,
  output logic        [63:0] o_rt_data,
  output logic        [4:0]  o_rd,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic               o_RegWrite,
  output logic               o_MemToReg,
  output logic               o_take_branch,
  output logic        [63:0] o_branch_target,
  output logic               o_flag_Z,
  output logic               o_flag_N,
  output logic               o_misalign
);

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_B    = 3'd1;
  localparam logic [2:0] BR_CBZ  = 3'd2;
  localparam logic [2:0] BR_CBNZ = 3'd3;
  localparam logic [2:0] BR_EQ   = 3'd4;
  localparam logic [2:0] BR_NE   = 3'd5;
  localparam logic [2:0] BR_LT   = 3'd6;
  localparam logic [2:0] BR_GE   = 3'd7;

  logic        r_valid;
  logic [63:0] r_ALURes;
  logic [63:0] r_rt_data;
  logic [4:0]  r_rd;
  logic        r_MemRead;
  logic        r_MemWrite;
  logic        r_RegWrite;
  logic        r_MemToReg;
  logic        r_take_branch;
  logic [63:0] r_branch_target;
  logic        r_flag_Z;
  logic        r_flag_N;
  logic        r_misalign;

  logic w_cond;
  logic w_misalign;
  logic w_mem_ok;

  // Conditional branches read the flags as they stood before this edge, so a
  // flag-setting instruction never steers its own branch.
  always_comb begin
    w_cond = 1'b0;
    case (i_branch_type)
      BR_NONE: w_cond = 1'b0;
      BR_B:    w_cond = 1'b1;
      BR_CBZ:  w_cond = i_Z;
      BR_CBNZ: w_cond = ~i_Z;
      BR_EQ:   w_cond = r_flag_Z;
      BR_NE:   w_cond = ~r_flag_Z;
      BR_LT:   w_cond = r_flag_N;
      BR_GE:   w_cond = ~r_flag_N;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_misalign = i_valid & (i_MemRead | i_MemWrite) & (i_ALURes[2:0] != 3'd0);
  assign w_mem_ok   = i_valid & ~w_misalign;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid         <= 1'b0;
      r_ALURes        <= 64'd0;
      r_rt_data       <= 64'd0;
      r_rd            <= 5'd0;
      r_MemRead       <= 1'b0;
      r_MemWrite      <= 1'b0;
      r_RegWrite      <= 1'b0;
      r_MemToReg      <= 1'b0;
      r_take_branch   <= 1'b0;
      r_branch_target <= 64'd0;
      r_flag_Z        <= 1'b0;
      r_flag_N        <= 1'b0;
      r_misalign      <= 1'b0;
    end else if (i_flush) begin
      // Data fields and flags are left as they were; only side-effecting bits die.
      r_valid       <= 1'b0;
      r_MemRead     <= 1'b0;
      r_MemWrite    <= 1'b0;
      r_RegWrite    <= 1'b0;
      r_take_branch <= 1'b0;
      r_misalign    <= 1'b0;
    end else if (!i_stall) begin
      r_valid         <= i_valid;
      r_ALURes        <= i_ALURes;
      r_rt_data       <= i_rt_data;
      r_rd            <= i_rd;
      r_MemToReg      <= i_MemToReg;
      r_branch_target <= i_branch_target;
      r_MemRead       <= w_mem_ok & i_MemRead;
      r_MemWrite      <= w_mem_ok & i_MemWrite;
      r_RegWrite      <= w_mem_ok & i_RegWrite;
      r_take_branch   <= i_valid & w_cond;
      r_misalign      <= w_misalign;
      if (i_valid && i_set_flags) begin
        r_flag_Z <= i_Z;
        r_flag_N <= i_N;
      end
    end
  end

  assign o_ready         = ~i_stall;
  assign o_valid         = r_valid;
  assign o_ALURes        = r_ALURes;
  assign o_rt_data       = r_rt_data;
  assign o_rd            = r_rd;
  assign o_MemRead       = r_MemRead;
  assign o_MemWrite      = r_MemWrite;
  assign o_RegWrite      = r_RegWrite;
  assign o_MemToReg      = r_MemToReg;
  assign o_take_branch   = r_take_branch;
  assign o_branch_target = r_branch_target;
  assign o_flag_Z        = r_flag_Z;
  assign o_flag_N        = r_flag_N;
  assign o_misalign      = r_misalign;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a linear sequence of steps, each followed by
// immediate assertions against hand-computed values.
module tb_ex_mem_stage;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic signed [63:0] i_ALURes;
  logic               i_Z;
  logic               i_N;
  logic        [63:0] i_rt_data;
  logic        [4:0]  i_rd;
  logic        [63:0] i_branch_target;
  logic               i_MemRead;
  logic               i_MemWrite;
  logic               i_RegWrite;
  logic               i_MemToReg;
  logic               i_set_flags;
  logic        [2:0]  i_branch_type;
  logic               i_stall;
  logic               i_flush;
  logic               o_ready;
  logic               o_valid;
  logic        [63:0] o_ALURes;
  logic        [63:0] o_rt_data;
  logic        [4:0]  o_rd;
  logic               o_MemRead;
  logic               o_MemWrite;
  logic               o_RegWrite;
  logic               o_MemToReg;
  logic               o_take_branch;
  logic        [63:0] o_branch_target;
  logic               o_flag_Z;
  logic               o_flag_N;
  logic               o_misalign;

  int n_cmp = 0;
  int n_err = 0;

  ex_mem_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_ALURes(i_ALURes),
    .i_Z(i_Z), .i_N(i_N), .i_rt_data(i_rt_data), .i_rd(i_rd),
    .i_branch_target(i_branch_target), .i_MemRead(i_MemRead),
    .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite), .i_MemToReg(i_MemToReg),
    .i_set_flags(i_set_flags), .i_branch_type(i_branch_type),
    .i_stall(i_stall), .i_flush(i_flush), .o_ready(o_ready),
    .o_valid(o_valid), .o_ALURes(o_ALURes), .o_rt_data(o_rt_data),
    .o_rd(o_rd), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
    .o_RegWrite(o_RegWrite), .o_MemToReg(o_MemToReg),
    .o_take_branch(o_take_branch), .o_branch_target(o_branch_target),
    .o_flag_Z(o_flag_Z), .o_flag_N(o_flag_N), .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    i_valid = 0; i_ALURes = 0; i_Z = 0; i_N = 0; i_rt_data = 0; i_rd = 0;
    i_branch_target = 0; i_MemRead = 0; i_MemWrite = 0; i_RegWrite = 0;
    i_MemToReg = 0; i_set_flags = 0; i_branch_type = 0; i_stall = 0; i_flush = 0;
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"},   64'(o_valid), 64'd0);
    chk({tag, ".alures"},  o_ALURes, 64'd0);
    chk({tag, ".rtdata"},  o_rt_data, 64'd0);
    chk({tag, ".rd"},      64'(o_rd), 64'd0);
    chk({tag, ".ctrl"},    64'({o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg}), 64'd0);
    chk({tag, ".take"},    64'(o_take_branch), 64'd0);
    chk({tag, ".target"},  o_branch_target, 64'd0);
    chk({tag, ".flags"},   64'({o_flag_Z, o_flag_N}), 64'd0);
    chk({tag, ".misalign"}, 64'(o_misalign), 64'd0);
  endtask

  initial begin
    // Reset dominates a valid, flag-setting, branching instruction.
    clr_in();
    i_rst = 1; i_valid = 1; i_ALURes = 64'h55; i_rd = 5'd9; i_RegWrite = 1;
    i_set_flags = 1; i_Z = 1; i_N = 1; i_branch_type = 3'd1; i_branch_target = 64'h900;
    step();
    chk_all_zero("reset");
    $display("txn reset: o_valid=%0d", o_valid);

    // Plain capture.
    clr_in(); i_rst = 0;
    i_valid = 1; i_ALURes = 64'h10; i_RegWrite = 1; i_rd = 5'd5;
    chk("ready_idle", 64'(o_ready), 64'd1);
    step();
    chk("cap.valid", 64'(o_valid), 64'd1);
    chk("cap.alures", o_ALURes, 64'h10);
    chk("cap.rd", 64'(o_rd), 64'd5);
    chk("cap.regwrite", 64'(o_RegWrite), 64'd1);
    chk("cap.take", 64'(o_take_branch), 64'd0);
    $display("txn capture: alures=%h rd=%0d", o_ALURes, o_rd);

    // SUBS sets Z=1 N=0.
    clr_in(); i_valid = 1; i_set_flags = 1; i_Z = 1; i_N = 0; i_RegWrite = 1; i_rd = 5'd3;
    step();
    chk("subs.flagZ", 64'(o_flag_Z), 64'd1);
    chk("subs.flagN", 64'(o_flag_N), 64'd0);
    $display("txn subs: Z=%0d N=%0d", o_flag_Z, o_flag_N);

    // B.EQ uses flag_Z=1, i_Z deliberately 0.
    clr_in(); i_valid = 1; i_branch_type = 3'd4; i_branch_target = 64'hFFFF_0000_0000_0404;
    step();
    chk("beq.take", 64'(o_take_branch), 64'd1);
    chk("beq.target", o_branch_target, 64'hFFFF_0000_0000_0404);
    chk("beq.flagZ_hold", 64'(o_flag_Z), 64'd1);
    $display("txn b.eq: take=%0d", o_take_branch);

    // B.NE with flag_Z=1.
    clr_in(); i_valid = 1; i_branch_type = 3'd5; i_Z = 0;
    step();
    chk("bne.take", 64'(o_take_branch), 64'd0);
    $display("txn b.ne: take=%0d", o_take_branch);

    // Flags Z=0 N=1.
    clr_in(); i_valid = 1; i_set_flags = 1; i_Z = 0; i_N = 1;
    step();
    chk("subs2.flags", 64'({o_flag_Z, o_flag_N}), 64'b01);

    // CBZ with i_Z=1, i_N=1, flag_Z=0 -> taken.
    clr_in(); i_valid = 1; i_branch_type = 3'd2; i_Z = 1; i_N = 1;
    step();
    chk("cbz1.take", 64'(o_take_branch), 64'd1);
    $display("txn cbz z=1: take=%0d", o_take_branch);

    clr_in(); i_valid = 1; i_branch_type = 3'd2; i_Z = 0; i_N = 1;
    step();
    chk("cbz0.take", 64'(o_take_branch), 64'd0);
    $display("txn cbz z=0: take=%0d", o_take_branch);

    clr_in(); i_valid = 1; i_branch_type = 3'd3; i_Z = 0;
    step();
    chk("cbnz.take", 64'(o_take_branch), 64'd1);

    clr_in(); i_valid = 1; i_branch_type = 3'd6;
    step();
    chk("blt.take", 64'(o_take_branch), 64'd1);

    clr_in(); i_valid = 1; i_branch_type = 3'd7;
    step();
    chk("bge.take", 64'(o_take_branch), 64'd0);
    $display("txn b.lt/b.ge done: take=%0d", o_take_branch);

    // Flag-setting B.EQ sees old flag_Z=0; flags still update to 11.
    clr_in(); i_valid = 1; i_set_flags = 1; i_branch_type = 3'd4; i_Z = 1; i_N = 1;
    step();
    chk("sfbeq.take", 64'(o_take_branch), 64'd0);
    chk("sfbeq.flags", 64'({o_flag_Z, o_flag_N}), 64'b11);
    $display("txn set_flags+b.eq: take=%0d flags=%b%b", o_take_branch, o_flag_Z, o_flag_N);

    // Misaligned load.
    clr_in(); i_valid = 1; i_MemRead = 1; i_RegWrite = 1; i_MemToReg = 1; i_ALURes = 64'h1004;
    step();
    chk("mis.misalign", 64'(o_misalign), 64'd1);
    chk("mis.memread", 64'(o_MemRead), 64'd0);
    chk("mis.regwrite", 64'(o_RegWrite), 64'd0);
    chk("mis.alures", o_ALURes, 64'h1004);
    $display("txn misaligned load: misalign=%0d", o_misalign);

    // Aligned store with a full-width data word.
    clr_in(); i_valid = 1; i_MemWrite = 1; i_ALURes = 64'h1008; i_rt_data = 64'hDEADBEEF_CAFEF00D;
    step();
    chk("st.memwrite", 64'(o_MemWrite), 64'd1);
    chk("st.misalign", 64'(o_misalign), 64'd0);
    chk("st.rtdata", o_rt_data, 64'hDEADBEEF_CAFEF00D);
    $display("txn store: data=%h", o_rt_data);

    // Bubble: controls asserted but i_valid=0.
    clr_in(); i_valid = 0; i_RegWrite = 1; i_MemRead = 1; i_MemWrite = 1; i_branch_type = 3'd1;
    i_ALURes = 64'h3;
    step();
    chk("bub.ctrl", 64'({o_valid, o_MemRead, o_MemWrite, o_RegWrite, o_take_branch, o_misalign}), 64'd0);
    $display("txn bubble: valid=%0d", o_valid);

    // Valid B instruction, then a 3-cycle stall with changing inputs.
    clr_in(); i_valid = 1; i_ALURes = 64'hAA; i_rd = 5'd7; i_RegWrite = 1; i_branch_type = 3'd1;
    i_branch_target = 64'h2000;
    step();
    chk("pre.take", 64'(o_take_branch), 64'd1);
    for (int c = 0; c < 3; c++) begin
      clr_in(); i_stall = 1; i_valid = c[0]; i_ALURes = 64'(c + 100); i_rd = 5'(c + 20);
      i_set_flags = 1; i_Z = 0; i_N = 0; i_MemWrite = 1;
      #1;
      chk("stall.ready", 64'(o_ready), 64'd0);
      step();
      chk("stall.valid", 64'(o_valid), 64'd1);
      chk("stall.alures", o_ALURes, 64'hAA);
      chk("stall.rd", 64'(o_rd), 64'd7);
      chk("stall.take", 64'(o_take_branch), 64'd1);
      chk("stall.memwrite", 64'(o_MemWrite), 64'd0);
      chk("stall.flags", 64'({o_flag_Z, o_flag_N}), 64'b11);
      $display("txn stall %0d: alures=%h rd=%0d", c, o_ALURes, o_rd);
    end

    // Stall plus flush: flush wins, flags untouched.
    clr_in(); i_stall = 1; i_flush = 1; i_valid = 1; i_set_flags = 1; i_Z = 0; i_N = 0;
    step();
    chk("flush.ctrl", 64'({o_valid, o_MemRead, o_MemWrite, o_RegWrite, o_take_branch, o_misalign}), 64'd0);
    chk("flush.flags", 64'({o_flag_Z, o_flag_N}), 64'b11);
    $display("txn flush: valid=%0d flags=%b%b", o_valid, o_flag_Z, o_flag_N);

    // Valid instruction held under stall, then reset discards it.
    clr_in(); i_valid = 1; i_ALURes = 64'h40; i_RegWrite = 1; i_rd = 5'd2; i_branch_target = 64'h88;
    step();
    chk("prerst.valid", 64'(o_valid), 64'd1);
    clr_in(); i_stall = 1;
    step();
    chk("prerst.hold", o_ALURes, 64'h40);
    i_rst = 1; i_flush = 1; i_valid = 1;
    step();
    chk_all_zero("rst_stall");
    $display("txn reset under stall: valid=%0d", o_valid);

    // First capture after reset.
    clr_in(); i_rst = 0; i_valid = 1; i_ALURes = -64'sd8; i_rd = 5'd31; i_MemRead = 1;
    i_RegWrite = 1; i_MemToReg = 1;
    step();
    chk("post.valid", 64'(o_valid), 64'd1);
    chk("post.alures", o_ALURes, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("post.ctrl", 64'({o_MemRead, o_RegWrite, o_MemToReg, o_misalign}), 64'b1110);
    $display("txn post-reset capture: alures=%h", o_ALURes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
